// File: rtl/bits_unpack_if.sv
// Stream-in / word-out bundle for the bit-pair unpacker.
// master drives the stream and observes results; slave is the unpacker itself.
interface bits_unpack_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_nd;
  logic [WIDTH-1:0] out_data;
  logic             out_nd;
  logic             error;
  logic             busy;

  modport master (
    output in_data, in_nd,
    input  out_data, out_nd, error, busy
  );

  modport slave (
    input  in_data, in_nd,
    output out_data, out_nd, error, busy
  );
endinterface

// File: rtl/bits_unpack.sv
// Reassembles a WIDTH-bit word from alternating (bit position, bit content) words, bit 0 first.
// Output word and pulses are registered, 1 cycle after the last content word; the input is never stalled.
module bits_unpack #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  bits_unpack_if.slave  bus
);

  function automatic int clog2f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int            CW   = clog2f(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_POS, S_VAL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_nd_q, out_nd_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] cnt_ext;
  assign cnt_ext = {{(WIDTH-CW){1'b0}}, cnt_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_POS;
      cnt_q      <= '0;
      asm_q      <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    out_data_d = out_data_q;
    out_nd_d   = 1'b0;
    error_d    = 1'b0;
    if (bus.in_nd) begin
      case (state_q)
        S_POS: begin
          if (bus.in_data == cnt_ext) begin
            state_d = S_VAL;
          end else if (bus.in_data == '0) begin
            // Position 0 out of order: drop the partial frame and start a new one.
            error_d = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = S_VAL;
          end else begin
            error_d = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
          end
        end
        S_VAL: begin
          state_d = S_POS;
          if (bus.in_data[WIDTH-1:1] != '0) begin
            error_d = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
          end else if (cnt_q == LAST) begin
            out_data_d = {bus.in_data[0], asm_q[WIDTH-2:0]};
            out_nd_d   = 1'b1;
            cnt_d      = '0;
            asm_d      = '0;
          end else begin
            asm_d[cnt_q] = bus.in_data[0];
            cnt_d        = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_POS;
          cnt_d   = '0;
          asm_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.out_data = out_data_q;
    bus.out_nd   = out_nd_q;
    bus.error    = error_q;
    bus.busy     = (state_q == S_VAL) || (cnt_q != '0);
  end

endmodule

// File: tb/tb_bits_unpack.sv
module tb_bits_unpack;

  typedef struct {
    logic       nd;
    logic [7:0] din;
    logic       exp_nd;
    logic [7:0] exp_dat;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];
  logic [7:0] cur;

  bits_unpack_if #(.WIDTH(8)) bus ();

  bits_unpack #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic vec(input logic nd, input logic [7:0] din, input logic enp,
                     input logic [7:0] edat, input logic eerr, input logic ebusy);
    vec_t v;
    v.nd = nd; v.din = din; v.exp_nd = enp; v.exp_dat = edat; v.exp_err = eerr; v.exp_busy = ebusy;
    tbl.push_back(v);
  endtask

  // Invalid cycle with junk data: pulses drop, everything else holds.
  task automatic idle();
    vec_t p;
    p = tbl[tbl.size()-1];
    vec(1'b0, 8'hEE, 1'b0, p.exp_dat, 1'b0, p.exp_busy);
  endtask

  task automatic frame(input logic [7:0] val, input bit toggle, input bit skip_pos0);
    for (int i = 0; i < 8; i++) begin
      if (!(skip_pos0 && i == 0)) begin
        vec(1'b1, 8'(i), 1'b0, cur, 1'b0, 1'b1);
        if (toggle) idle();
      end
      vec(1'b1, {7'd0, val[i]}, (i == 7), (i == 7) ? val : cur, 1'b0, (i != 7));
      if (toggle) idle();
    end
    cur = val;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.in_nd   = tbl[i].nd;
      bus.in_data = tbl[i].din;
      @(posedge clk);
      #1;
      check({tag, ".out_nd"},   i, 32'(bus.out_nd),   32'(tbl[i].exp_nd));
      check({tag, ".out_data"}, i, 32'(bus.out_data), 32'(tbl[i].exp_dat));
      check({tag, ".error"},    i, 32'(bus.error),    32'(tbl[i].exp_err));
      check({tag, ".busy"},     i, 32'(bus.busy),     32'(tbl[i].exp_busy));
    end
    @(negedge clk);
    bus.in_nd = 1'b0;
    tbl.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur    = 8'h00;
    reset  = 1'b0;
    bus.in_nd   = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_data", 0, 32'(bus.out_data), 32'h0);
    check("rst.out_nd",   0, 32'(bus.out_nd),   32'h0);
    check("rst.error",    0, 32'(bus.error),    32'h0);
    check("rst.busy",     0, 32'(bus.busy),     32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Full-rate back-to-back frames, then the same with idle cycles interleaved.
    frame(8'hA5, 1'b0, 1'b0);
    frame(8'h3C, 1'b0, 1'b0);
    frame(8'hA5, 1'b1, 1'b0);
    frame(8'h3C, 1'b1, 1'b0);

    // Wrong position mid-frame: discard, then a clean frame.
    for (int i = 0; i < 4; i++) begin
      vec(1'b1, 8'(i), 1'b0, cur, 1'b0, 1'b1);
      vec(1'b1, 8'h01, 1'b0, cur, 1'b0, 1'b1);
    end
    vec(1'b1, 8'd5, 1'b0, cur, 1'b1, 1'b0);
    frame(8'hFF, 1'b0, 1'b0);

    // Position 0 mid-frame restarts a frame with a single error.
    for (int i = 0; i < 5; i++) begin
      vec(1'b1, 8'(i), 1'b0, cur, 1'b0, 1'b1);
      vec(1'b1, 8'h00, 1'b0, cur, 1'b0, 1'b1);
    end
    vec(1'b1, 8'd0, 1'b0, cur, 1'b1, 1'b1);
    frame(8'h81, 1'b0, 1'b1);

    // Nonzero position while idle is rejected and state stays idle.
    vec(1'b1, 8'd6, 1'b0, cur, 1'b1, 1'b0);
    vec(1'b1, 8'd6, 1'b0, cur, 1'b1, 1'b0);

    // Illegal content value.
    vec(1'b1, 8'd0, 1'b0, cur, 1'b0, 1'b1);
    vec(1'b1, 8'h02, 1'b0, cur, 1'b1, 1'b0);
    frame(8'h55, 1'b0, 1'b0);
    run_table("tbl1");

    // Reset in the middle of a frame.
    bus.in_nd = 1'b1; bus.in_data = 8'd0; @(negedge clk);
    bus.in_data = 8'd1;                   @(negedge clk);
    bus.in_data = 8'd1;                   @(negedge clk);
    bus.in_data = 8'd0;
    #1;
    check("mid.busy", 0, 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check("arst.out_data", 0, 32'(bus.out_data), 32'h0);
    check("arst.busy",     0, 32'(bus.busy),     32'h0);
    check("arst.out_nd",   0, 32'(bus.out_nd),   32'h0);
    check("arst.error",    0, 32'(bus.error),    32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("inrst.out_data", 0, 32'(bus.out_data), 32'h0);
    check("inrst.busy",     0, 32'(bus.busy),     32'h0);
    check("inrst.out_nd",   0, 32'(bus.out_nd),   32'h0);
    check("inrst.error",    0, 32'(bus.error),    32'h0);
    @(negedge clk);
    bus.in_nd = 1'b0;
    reset = 1'b1;
    cur = 8'h00;
    frame(8'h0F, 1'b0, 1'b0);
    run_table("tbl2");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
